// File: rtl/radix4_divider_24by12_if.sv
// Operand/result handshake bundle for the radix-4 divider.
// The producer side drives operands and takes results; the divider is the slave.
interface radix4_divider_24by12_if #(
  parameter int N = 12
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] X;
  logic [N-1:0]   Y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;
  logic           DZ;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, Q, R, DZ
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, Q, R, DZ
  );
endinterface

// File: rtl/radix4_divider_24by12.sv
// Sequential unsigned radix-4 restoring divider: 2N-bit dividend by N-bit
// divisor, two quotient bits retired per clock, N iterations per division.
module radix4_divider_24by12 #(
  parameter int N = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  radix4_divider_24by12_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_reg, state_next;
  logic [2*N-1:0] x_reg, x_next;
  logic [2*N-1:0] q_reg, q_next;
  logic [N-1:0]   y_reg, y_next;
  logic [N-1:0]   r_reg, r_next;
  // The partial remainder is always < Y, so N bits hold it; the N+2-bit
  // trial value T is rebuilt from it every cycle.
  logic [N-1:0]   pr_reg, pr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           dz_reg, dz_next;

  logic [N+1:0]   t_cur;
  logic [N+1:0]   mult [4];
  logic [3:1]     ge;
  logic [1:0]     digit;
  logic [N-1:0]   diff;

  // Trial value: previous remainder with the next two dividend bits appended.
  assign t_cur   = {pr_reg, x_reg[2*N-1 -: 2]};

  // Divisor multiples 0..3, with 3Y formed as 2Y + Y.
  assign mult[0] = '0;
  assign mult[1] = {2'b00, y_reg};
  assign mult[2] = {1'b0, y_reg, 1'b0};
  assign mult[3] = mult[2] + mult[1];

  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_cmp
      assign ge[gi] = (t_cur >= mult[gi]);
    end
  endgenerate

  // Quotient digit: the largest multiple not exceeding T (comparisons are monotone).
  always_comb begin
    digit = 2'd0;
    if (ge[3])      digit = 2'd3;
    else if (ge[2]) digit = 2'd2;
    else if (ge[1]) digit = 2'd1;
  end

  // The true difference is < Y < 2^N, so modulo-2^N subtraction is exact.
  assign diff = t_cur[N-1:0] - mult[digit][N-1:0];

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.Q         = q_reg;
  assign bus.R         = r_reg;
  assign bus.DZ        = dz_reg;

  // State and datapath registers; reset discards any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      pr_reg    <= '0;
      cnt_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      pr_reg    <= pr_next;
      cnt_reg   <= cnt_next;
      dz_reg    <= dz_next;
    end
  end

  // Next-state and datapath update for accept, iterate and hand-off.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    pr_next    = pr_reg;
    cnt_next   = cnt_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          x_next = bus.X;
          y_next = bus.Y;
          if (bus.Y == '0) begin
            state_next = DONE;
            q_next     = '1;
            r_next     = bus.X[N-1:0];
            dz_next    = 1'b1;
          end else begin
            state_next = CALC;
            pr_next    = '0;
            cnt_next   = '0;
            dz_next    = 1'b0;
          end
        end
      end
      CALC: begin
        pr_next  = diff;
        q_next   = {q_reg[2*N-3:0], digit};
        x_next   = {x_reg[2*N-3:0], 2'b00};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          state_next = DONE;
          r_next     = diff;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
